// File: rtl/mipi_rx_frame_assembler.sv
// Purpose: hunt for a sync beat on one virtual channel, then pack DLEN payload bytes from BEAT_BYTES-wide MIPI beats.
// Latency: data_available rises 1 cycle after the beat that completes the payload; abort pulses frame_err 1 cycle later.
// Backpressure: a completed payload is held until data_ready; sync beats arriving while held are counted in drop_cnt.
module mipi_rx_frame_assembler #(
  parameter int         DLEN       = 6,
  parameter int         BEAT_BYTES = 6,
  parameter logic [1:0] VC_ID      = 2'd0,
  parameter logic [7:0] SYNC_BYTE  = 8'h7E,
  parameter int         TIMEOUT    = 1024
) (
  input  logic              rx_pixel_clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [63:0]       rx_data,
  input  logic [1:0]        rx_vc,
  input  logic [17:0]       rx_error,
  output logic [DLEN*8-1:0] data,
  output logic              data_available,
  input  logic              data_ready,
  output logic              busy,
  output logic              frame_err,
  output logic [15:0]       drop_cnt
);

  localparam int DW = DLEN * 8;
  localparam int CW = $clog2(DLEN + 1);
  localparam int IW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  // Illegal geometry is rejected at elaboration rather than producing odd hardware.
  if (BEAT_BYTES < 1 || BEAT_BYTES > 8 || DLEN < 1) begin : g_bad_params
    $error("mipi_rx_frame_assembler: BEAT_BYTES must be 1..8 and DLEN at least 1");
  end

  typedef enum logic [1:0] {HUNT, COLLECT, HOLD} state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   data_q, data_d;
  logic            avail_q, avail_d;
  logic            busy_q, busy_d;
  logic            frame_err_q, frame_err_d;
  logic [15:0]     drop_q, drop_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   idle_q, idle_d;

  logic            beat_acc;
  logic            beat_err;
  logic            is_sync;
  int              rem;
  int              take;
  logic [DW-1:0]   data_app;

  // Bytes above BEAT_BYTES are never looked at; fold them away so they are visibly intentional.
  logic unused_rx;
  assign unused_rx = ^rx_data;

  // Decode the current beat: ownership, sync pattern, and the payload it would append.
  always_comb begin
    beat_acc = rx_valid && (rx_vc == VC_ID);
    beat_err = rx_valid && (rx_error != 18'd0);
    is_sync  = 1'b1;
    for (int i = 0; i < BEAT_BYTES; i++) begin
      if (rx_data[8*i +: 8] != SYNC_BYTE) is_sync = 1'b0;
    end
    rem  = DLEN - int'(cnt_q);
    take = (rem < BEAT_BYTES) ? rem : BEAT_BYTES;
    // Highest kept byte goes in first so the earliest byte ends up most significant.
    data_app = data_q;
    for (int i = BEAT_BYTES - 1; i >= 0; i--) begin
      if (i < take) data_app = (data_app << 8) | DW'(rx_data[8*i +: 8]);
    end
  end

  // Next-state and next-output computation for HUNT / COLLECT / HOLD.
  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    avail_d     = avail_q;
    frame_err_d = 1'b0;
    drop_d      = drop_q;
    cnt_d       = cnt_q;
    idle_d      = idle_q;
    case (state_q)
      HUNT: begin
        if (beat_acc && is_sync) begin
          data_d  = '0;
          cnt_d   = '0;
          idle_d  = '0;
          state_d = COLLECT;
        end
      end
      COLLECT: begin
        if (beat_err) begin
          // An error beat wins even if it would have completed the payload.
          state_d     = HUNT;
          frame_err_d = 1'b1;
        end else if (beat_acc) begin
          data_d = data_app;
          cnt_d  = cnt_q + CW'(take);
          idle_d = '0;
          if ((int'(cnt_q) + take) == DLEN) begin
            state_d = HOLD;
            avail_d = 1'b1;
          end
        end else if (TIMEOUT != 0) begin
          if ((int'(idle_q) + 1) == TIMEOUT) begin
            state_d     = HUNT;
            frame_err_d = 1'b1;
          end else begin
            idle_d = idle_q + IW'(1);
          end
        end
      end
      HOLD: begin
        if (beat_acc && is_sync && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
        if (data_ready) begin
          avail_d = 1'b0;
          state_d = HUNT;
        end
      end
      default: state_d = HUNT;
    endcase
    busy_d = (state_d != HUNT);
  end

  // State and all outputs register here; reset discards any partial payload silently.
  always_ff @(posedge rx_pixel_clk) begin
    if (rst) begin
      state_q     <= HUNT;
      data_q      <= '0;
      avail_q     <= 1'b0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
      drop_q      <= '0;
      cnt_q       <= '0;
      idle_q      <= '0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      avail_q     <= avail_d;
      busy_q      <= busy_d;
      frame_err_q <= frame_err_d;
      drop_q      <= drop_d;
      cnt_q       <= cnt_d;
      idle_q      <= idle_d;
    end
  end

  assign data           = data_q;
  assign data_available = avail_q;
  assign busy           = busy_q;
  assign frame_err      = frame_err_q;
  assign drop_cnt       = drop_q;

endmodule

// File: tb/tb_mipi_rx_frame_assembler.sv
// Purpose: self-checking bench for mipi_rx_frame_assembler over three parameter sets sharing one stimulus bus.
// Latency: inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
// Backpressure: data_ready is driven by the bench to hold or release completed payloads.
module tb_mipi_rx_frame_assembler;

  localparam logic [63:0] SYNC64 = 64'h7E7E_7E7E_7E7E_7E7E;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_valid;
  logic [63:0] rx_data;
  logic [1:0]  rx_vc;
  logic [17:0] rx_error;
  logic        data_ready;

  logic [47:0] u0_data;
  logic        u0_av, u0_busy, u0_fe;
  logic [15:0] u0_drop;
  logic [63:0] u1_data;
  logic        u1_av, u1_busy, u1_fe;
  logic [15:0] u1_drop;
  logic [95:0] u2_data;
  logic        u2_av, u2_busy, u2_fe;
  logic [15:0] u2_drop;

  int total = 0;
  int bad   = 0;
  logic [95:0] exp_q[$];

  always #5 clk = ~clk;

  mipi_rx_frame_assembler #(.DLEN(6), .BEAT_BYTES(6)) u0 (
    .rx_pixel_clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .rx_vc(rx_vc),
    .rx_error(rx_error), .data(u0_data), .data_available(u0_av), .data_ready(data_ready),
    .busy(u0_busy), .frame_err(u0_fe), .drop_cnt(u0_drop));

  mipi_rx_frame_assembler #(.DLEN(8), .BEAT_BYTES(6)) u1 (
    .rx_pixel_clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .rx_vc(rx_vc),
    .rx_error(rx_error), .data(u1_data), .data_available(u1_av), .data_ready(data_ready),
    .busy(u1_busy), .frame_err(u1_fe), .drop_cnt(u1_drop));

  mipi_rx_frame_assembler #(.DLEN(12), .BEAT_BYTES(6), .TIMEOUT(16)) u2 (
    .rx_pixel_clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .rx_vc(rx_vc),
    .rx_error(rx_error), .data(u2_data), .data_available(u2_av), .data_ready(data_ready),
    .busy(u2_busy), .frame_err(u2_fe), .drop_cnt(u2_drop));

  function automatic logic av_of(input int inst);
    case (inst)
      0:       return u0_av;
      1:       return u1_av;
      default: return u2_av;
    endcase
  endfunction

  function automatic logic [95:0] data_of(input int inst);
    case (inst)
      0:       return {48'd0, u0_data};
      1:       return {32'd0, u1_data};
      default: return u2_data;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [1:0] vc, input logic [63:0] d, input logic [17:0] err);
    rx_valid = 1'b1;
    rx_vc    = vc;
    rx_data  = d;
    rx_error = err;
    tick();
    rx_valid = 1'b0;
    rx_data  = '0;
    rx_error = '0;
    rx_vc    = 2'd0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    rx_valid   = 1'b0;
    rx_data    = '0;
    rx_vc      = 2'd0;
    rx_error   = '0;
    data_ready = 1'b0;
    idle(2);
    rst = 1'b0;
  endtask

  // Wait (bounded) for a payload on one instance, compare it with the scoreboard head, then accept it.
  task automatic take_payload(input int inst, input string name);
    int n = 0;
    logic [95:0] exp;
    while (!av_of(inst) && n < 40) begin
      tick();
      n++;
    end
    total++;
    if (!av_of(inst)) begin
      bad++;
      $display("FAIL %s_timeout: data_available never rose within %0d cycles", name, n);
    end else if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL %s_unexpected: payload %h with empty scoreboard", name, data_of(inst));
    end else begin
      exp = exp_q.pop_front();
      total++;
      if (data_of(inst) !== exp) begin
        bad++;
        $display("FAIL %s_data: got %h want %h", name, data_of(inst), exp);
      end
      data_ready = 1'b1;
      tick();
      data_ready = 1'b0;
      if (av_of(inst) !== 1'b0) begin
        bad++;
        $display("FAIL %s_release: data_available %b want 0 after handshake", name, av_of(inst));
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({u0_data, u0_av, u0_busy, u0_fe, u0_drop} !== '0) begin
      bad++;
      $display("FAIL reset_state: data=%h av=%b busy=%b fe=%b drop=%0d want all 0",
               u0_data, u0_av, u0_busy, u0_fe, u0_drop);
    end
  endtask

  task automatic test_basic();
    do_reset();
    beat(2'd0, SYNC64, '0);
    total++;
    if (u0_busy !== 1'b1 || u0_av !== 1'b0) begin
      bad++;
      $display("FAIL basic_after_sync: busy=%b av=%b want busy=1 av=0", u0_busy, u0_av);
    end
    exp_q.push_back(96'h1122_3344_5566);
    beat(2'd0, 64'h0000_1122_3344_5566, '0);
    total++;
    if (u0_av !== 1'b1) begin
      bad++;
      $display("FAIL basic_latency: av=%b want 1 one cycle after last beat", u0_av);
    end
    take_payload(0, "basic");
  endtask

  task automatic test_partial_beat();
    do_reset();
    beat(2'd0, SYNC64, '0);
    beat(2'd0, 64'h0000_AABB_CCDD_EEFF, '0);
    total++;
    if (u1_av !== 1'b0 || u1_busy !== 1'b1) begin
      bad++;
      $display("FAIL partial_mid: av=%b busy=%b want av=0 busy=1", u1_av, u1_busy);
    end
    exp_q.push_back(96'hAABB_CCDD_EEFF_1122);
    beat(2'd0, 64'h0000_5566_9988_1122, '0);
    take_payload(1, "partial");
  endtask

  task automatic test_hold_drop();
    do_reset();
    beat(2'd0, SYNC64, '0);
    beat(2'd0, 64'h0000_0102_0304_0506, '0);
    for (int i = 0; i < 3; i++) beat(2'd0, SYNC64, '0);
    total++;
    if (u0_drop !== 16'd3 || u0_data !== 48'h0102_0304_0506 || u0_av !== 1'b1) begin
      bad++;
      $display("FAIL hold_drop3: drop=%0d data=%h av=%b want 3 010203040506 1", u0_drop, u0_data, u0_av);
    end
    data_ready = 1'b1;
    beat(2'd0, SYNC64, '0);
    data_ready = 1'b0;
    total++;
    if (u0_av !== 1'b0 || u0_drop !== 16'd4 || u0_busy !== 1'b0) begin
      bad++;
      $display("FAIL hold_handshake: av=%b drop=%0d busy=%b want 0 4 0", u0_av, u0_drop, u0_busy);
    end
    beat(2'd0, SYNC64, '0);
    total++;
    if (u0_busy !== 1'b1 || u0_drop !== 16'd4) begin
      bad++;
      $display("FAIL hold_resync: busy=%b drop=%0d want 1 4", u0_busy, u0_drop);
    end
    exp_q.push_back(96'h7E7E_0000_FFEE);
    beat(2'd0, 64'h0000_7E7E_0000_FFEE, '0);
    take_payload(0, "hold_next");
  endtask

  task automatic test_vc_filter();
    do_reset();
    beat(2'd1, SYNC64, '0);
    beat(2'd1, 64'h0000_1111_2222_3333, '0);
    total++;
    if (u0_busy !== 1'b0 || u0_av !== 1'b0) begin
      bad++;
      $display("FAIL vc_ignore: busy=%b av=%b want 0 0", u0_busy, u0_av);
    end
    beat(2'd0, SYNC64, '0);
    exp_q.push_back(96'h1111_2222_3333);
    beat(2'd0, 64'h0000_1111_2222_3333, '0);
    take_payload(0, "vc_accept");
  endtask

  task automatic test_abort();
    do_reset();
    beat(2'd0, SYNC64, '0);
    beat(2'd0, 64'h0000_A1A2_A3A4_A5A6, '0);
    idle(15);
    total++;
    if (u2_fe !== 1'b0 || u2_busy !== 1'b1) begin
      bad++;
      $display("FAIL timeout_early: fe=%b busy=%b after 15 idle want 0 1", u2_fe, u2_busy);
    end
    idle(1);
    total++;
    if (u2_fe !== 1'b1 || u2_busy !== 1'b0 || u2_av !== 1'b0 || u2_data !== 96'hA1A2_A3A4_A5A6) begin
      bad++;
      $display("FAIL timeout_abort: fe=%b busy=%b av=%b data=%h want 1 0 0 a1a2a3a4a5a6",
               u2_fe, u2_busy, u2_av, u2_data);
    end
    idle(1);
    total++;
    if (u2_fe !== 1'b0) begin
      bad++;
      $display("FAIL timeout_pulse: fe=%b want 0 one cycle after pulse", u2_fe);
    end
    beat(2'd0, SYNC64, '0);
    beat(2'd0, 64'h0000_0102_0304_0506, '0);
    beat(2'd0, 64'h0000_0708_090A_0B0C, 18'h1);
    total++;
    if (u2_fe !== 1'b1 || u2_av !== 1'b0 || u2_busy !== 1'b0) begin
      bad++;
      $display("FAIL error_abort: fe=%b av=%b busy=%b want 1 0 0", u2_fe, u2_av, u2_busy);
    end
    idle(1);
    total++;
    if (u2_fe !== 1'b0 || u2_av !== 1'b0) begin
      bad++;
      $display("FAIL error_after: fe=%b av=%b want 0 0", u2_fe, u2_av);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    beat(2'd0, SYNC64, '0);
    beat(2'd0, 64'h0000_DEAD_BEEF_0001, '0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if ({u2_data, u2_av, u2_busy, u2_fe, u2_drop} !== '0) begin
      bad++;
      $display("FAIL reset_mid: data=%h av=%b busy=%b fe=%b drop=%0d want all 0",
               u2_data, u2_av, u2_busy, u2_fe, u2_drop);
    end
    idle(1);
    total++;
    if (u2_fe !== 1'b0 || u2_busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_fe: fe=%b busy=%b want 0 0", u2_fe, u2_busy);
    end
    beat(2'd0, SYNC64, '0);
    beat(2'd0, 64'h0000_0102_0304_0506, '0);
    exp_q.push_back(96'h0102_0304_0506_0708_090A_0B0C);
    beat(2'd0, 64'h0000_0708_090A_0B0C, '0);
    take_payload(2, "reset_recover");
  endtask

  initial begin
    rst        = 1'b1;
    rx_valid   = 1'b0;
    rx_data    = '0;
    rx_vc      = 2'd0;
    rx_error   = '0;
    data_ready = 1'b0;
    test_reset();
    test_basic();
    test_partial_beat();
    test_hold_drop();
    test_vc_filter();
    test_abort();
    test_reset_mid();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_empty: %0d payloads left, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mipi_rx_frame_assembler.md
Name: mipi_rx_frame_assembler

Overview:
Parametrised successor to the fixed 48-bit MIPI RX payload capture. It hunts for a sync beat on a selected virtual channel and assembles a DLEN-byte payload from a configurable number of bytes per MIPI beat. Each payload is presented behind a valid/ready handshake, with abort on timeout or PHY error, and drop/error accounting. It sits between the MIPI RX hard-IP outputs and the miner/UART consumers, in the rx_pixel_clk domain.

Parameters:
DLEN, 6, payload length in bytes; must be at least 1.
BEAT_BYTES, 6, valid bytes per rx_data beat, taken from rx_data[8*BEAT_BYTES-1:0]; range 1..8.
VC_ID, 0, virtual channel accepted (2 bits).
SYNC_BYTE, 8'h7E, marker byte; a sync beat has every one of its BEAT_BYTES bytes equal to SYNC_BYTE.
TIMEOUT, 1024, maximum idle cycles between beats in COLLECT; 0 disables the timeout.

Ports:
rx_pixel_clk  in  1  clock
rst  in  1  synchronous active-high reset
rx_valid  in  1  MIPI beat valid (my_mipi_rx_VALID)
rx_data  in  64  MIPI beat data (my_mipi_rx_DATA)
rx_vc  in  2  beat virtual channel (my_mipi_rx_VC)
rx_error  in  18  PHY/CSI error flags (my_mipi_rx_ERROR)
data  out  DLEN*8  assembled payload; first byte received is most significant
data_available  out  1  payload valid; held until accepted
data_ready  in  1  consumer accepts payload when data_available is also high
busy  out  1  high when state is not HUNT
frame_err  out  1  one-cycle pulse when a payload is aborted
drop_cnt  out  16  number of sync beats dropped while in HOLD; saturates at 16'hFFFF

Behaviour:
- One clock domain, rx_pixel_clk. All outputs are registered.
- Reset (rst=1 at a clock edge):
  - state goes to HUNT.
  - data=0, data_available=0, busy=0, frame_err=0, drop_cnt=0.
  - Internal byte and idle counters are cleared.
  - Reset takes priority over every other event, including mid-COLLECT and mid-HOLD; any partial payload is discarded with no frame_err.
- Accepted beat: rx_valid=1 and rx_vc==VC_ID. Beats from other VCs are ignored in every state and do not reset the idle counter.
- Each accepted beat consumes R = min(BEAT_BYTES, remaining) bytes:
  - data <= (data << 8*R) | rx_data[8*R-1:0].
  - Bytes above R in the final partial beat are discarded.
- HUNT:
  - An accepted sync beat clears data and the byte counter, then moves to COLLECT. The sync beat itself is not stored.
  - Other beats are ignored.
- COLLECT:
  - Every accepted beat is stored as payload, including bytes equal to SYNC_BYTE; there is no re-sync.
  - When the byte counter reaches DLEN on beat cycle N: state=HOLD and data_available=1 from cycle N+1.
  - Latency from the last payload beat to data_available is 1 cycle.
  - Abort when any bit of rx_error is set in a cycle with rx_valid=1, or when the idle count reaches TIMEOUT (TIMEOUT != 0).
    - On abort: return to HUNT and pulse frame_err for one cycle.
    - data keeps its partial contents; data_available stays 0.
  - If an error and a completing beat occur in the same cycle, the error wins: abort, no payload.
- HOLD:
  - data is stable and data_available=1 until data_ready=1.
  - In the handshake cycle: data_available=0 and state=HUNT on the next cycle.
  - Every accepted sync beat while in HOLD, including one in the handshake cycle itself, increments drop_cnt (saturating) and is otherwise ignored. Data beats in HOLD are ignored.
- busy = (state != HUNT), registered alongside the state.
- Idle counter width is clog2(TIMEOUT+1). It resets on every accepted beat and is cleared on entering COLLECT.
- Byte counter width is clog2(DLEN+1). No wrap-around occurs because the state leaves COLLECT at DLEN.
- Elaboration must fail on BEAT_BYTES outside 1..8 or DLEN=0.

Test Plan:
1. Basic capture (DLEN=6, BEAT_BYTES=6): VC0 beats 64'h7E7E7E7E7E7E then 64'h112233445566 -> data=48'h112233445566, with data_available=1 one cycle after the second beat and busy=1 from the cycle after the sync beat.
2. Multi-beat with partial final beat (DLEN=8, BEAT_BYTES=6): sync, 64'hAABBCCDDEEFF, 64'h...99881122 -> data=64'hAABBCCDDEEFF1122; the 0x9988 bytes are discarded.
3. Hold and drop: with a payload held and data_ready=0, send 3 sync beats -> drop_cnt=3 and data unchanged. Raise data_ready -> data_available=0 next cycle; a sync beat in the handshake cycle gives drop_cnt=4. The next sync beat is accepted.
4. VC filter: sync and payload beats on rx_vc=1 with VC_ID=0 -> no state change, busy=0. The same beats on rx_vc=0 are captured.
5. Abort paths (TIMEOUT=16, DLEN=12, BEAT_BYTES=6): sync, one data beat, then 16 idle cycles -> single-cycle frame_err pulse, HUNT. Repeat with rx_error=18'h1 on the completing beat -> frame_err, data_available stays 0.
6. Reset mid-COLLECT: assert rst for 1 cycle after the first payload beat -> all outputs 0 next cycle and no frame_err. A subsequent full frame captures correctly.
